apb_fifo_periph: RTL
====================

Name: apb_fifo_periph

Overview:
- APB subordinate placed on one PSELx slot of the APB manager (e.g. PERIPH_0 at 32'h1000_1000).
- Contains a DEPTH-entry 32-bit FIFO. The CPU pushes and pops it through memory-mapped registers.
- Status is readable, sticky error flags are write-1-to-clear, and an optional level interrupt is provided.
- The number of wait states inserted on PREADY is set by a parameter, so the manager's ACCESS-hold path gets exercised.

Parameters:
- DEPTH, 8, FIFO entries; power of 2, minimum 2.
- WAIT_STATES, 0, ACCESS cycles with PREADY low before PREADY rises; range 0..15.

Ports:
- PCLK  in  1  clock.
- PRESET  in  1  asynchronous, active-high reset.
- PADDR  in  32  address; only PADDR[3:2] decoded, all other bits ignored.
- PWRITE  in  1  1 = write, 0 = read.
- PENABLE  in  1  ACCESS phase.
- PSEL  in  1  select from the manager's decoder.
- PWDATA  in  32  write data.
- PRDATA  out  32  read data.
- PREADY  out  1  transfer complete.
- irq  out  1  level interrupt: irq_en AND NOT empty.

Behaviour:
- Register map (PADDR[3:2]):
  - 0 STATUS (R / W1C):
    - bit0 empty, bit1 full, bit2 overflow (sticky), bit3 underflow (sticky).
    - bits[15:8] count, zero-extended; all other bits 0.
    - Writing 1 to bit2 or bit3 clears that bit; other written bits are ignored.
  - 1 TXDATA (W): push PWDATA. Reads return 0.
  - 2 RXDATA (R): returns the head entry and pops it. Writes are ignored.
  - 3 CTRL (R/W):
    - bit0 irq_en.
    - bit1 flush: write 1 resets pointers and count; it is not stored and reads as 0.
    - bit0 is updated on the same write as a flush.
- Reset values:
  - PRDATA = 0, PREADY = 0, irq = 0.
  - Pointers = 0, count = 0, irq_en = 0, overflow = 0, underflow = 0.
  - FIFO storage is not reset.
- Wait-state counter:
  - Clears whenever !(PSEL && PENABLE).
  - While PSEL && PENABLE && !PREADY, it increments.
  - PREADY = PSEL && PENABLE && (wcnt == WAIT_STATES).
  - With WAIT_STATES = 0, PREADY is high in the first ACCESS cycle (zero-wait transfer).
  - The counter returns to 0 on the cycle after completion, so back-to-back transfers (ACCESS→SETUP) each see the full wait.
- Commit point: all side effects take effect exactly once, at the PCLK edge that ends a cycle with PSEL && PENABLE && PREADY. Side effects are push, pop, flush, W1C and irq_en update. The SETUP phase and wait cycles have no side effects.
- PRDATA is combinational and valid only while PSEL && PENABLE && !PWRITE && PREADY; otherwise it is 32'h0.
  - RXDATA: mem[rd_ptr], or 0 if empty.
  - STATUS: reflects state before the commit edge.
- Push when full: data is dropped, overflow ← 1, pointers and count unchanged.
- Pop when empty: PRDATA = 0, underflow ← 1, pointers unchanged.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. Count is $clog2(DEPTH)+1 bits. empty = (count == 0), full = (count == DEPTH).
- Only one APB transfer commits per cycle, so push and pop are never simultaneous.
- PSEL low, or PSEL high with PENABLE low: PREADY = 0, PRDATA = 0, no state change.
- If the manager drops PSEL mid-wait: no commit, and the wait counter clears.
- PRESET asserted at any time, including mid-ACCESS or mid-wait: all state immediately goes to reset values and no partial commit occurs. After release, the next transfer needs a full SETUP+ACCESS.
- irq is registered from irq_en and count: it rises one cycle after the commit that makes the condition true and falls one cycle after the commit that clears it.

Test Plan:
1. WAIT_STATES=0: write TXDATA 32'hDEAD_BEEF, then 32'h1234_5678; read STATUS -> 32'h0000_0200. Read RXDATA twice -> DEAD_BEEF then 1234_5678, each with PREADY in the first ACCESS cycle. STATUS then -> 32'h0000_0001.
2. Fill/overflow, DEPTH=8: push 0..8 (9 writes) -> STATUS 32'h0000_0806 (count=8, full, overflow). Write STATUS 32'h4 -> 32'h0000_0802. Pop 8 -> values 0..7 in order, wrapping through pointer 0.
3. Underflow: read RXDATA on an empty FIFO -> PRDATA 0, STATUS 32'h0000_0009. Write STATUS 32'h8 -> 32'h0000_0001.
4. WAIT_STATES=3: read STATUS -> PREADY low for 3 ACCESS cycles, high on the 4th. Only one pop per RXDATA read even with waits, checked by count decrementing by exactly 1. Back-to-back SETUP after ACCESS repeats the 3-cycle wait.
5. CTRL: write 32'h1 with FIFO empty -> irq 0. Push one word -> irq 1 one cycle after commit. Write CTRL 32'h3 -> flush, count 0, irq 0 next cycle, CTRL reads 32'h1.
6. Reset mid-op: push 3 words, start an RXDATA read with WAIT_STATES=3, assert PRESET during the wait -> PREADY 0 and irq 0 immediately. After release STATUS reads 32'h0000_0001.

Source files
------------

// File: rtl/apb_fifo_periph.sv
// APB subordinate wrapping a DEPTH x 32-bit FIFO.
// Register map on PADDR[3:2]: 0 STATUS (R/W1C), 1 TXDATA (W), 2 RXDATA (R, pops),
// 3 CTRL (bit0 irq_en, bit1 flush). PREADY is held low for WAIT_STATES ACCESS
// cycles. All side effects happen only on the edge that ends a PSEL && PENABLE &&
// PREADY cycle, so SETUP and wait cycles never change state.
// DEPTH must be a power of two >= 2 and at most 128 so that count fits STATUS[15:8].
module apb_fifo_periph #(
  parameter int DEPTH       = 8,
  parameter int WAIT_STATES = 0
) (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic [31:0] PADDR,
  input  logic        PWRITE,
  input  logic        PENABLE,
  input  logic        PSEL,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        irq
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [3:0]    WS_LAST  = 4'(WAIT_STATES);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  localparam logic [1:0] REG_STATUS = 2'd0;
  localparam logic [1:0] REG_TXDATA = 2'd1;
  localparam logic [1:0] REG_RXDATA = 2'd2;
  localparam logic [1:0] REG_CTRL   = 2'd3;

  // FIFO storage, intentionally not reset
  logic [31:0] mem_r [DEPTH];

  logic [AW-1:0] wr_ptr_r, rd_ptr_r;
  logic [CW-1:0] count_r;
  logic          ovf_r, udf_r, irq_en_r, irq_r;
  logic [3:0]    wcnt_r;

  logic [AW-1:0] wr_ptr_s, rd_ptr_s;
  logic [CW-1:0] count_s;
  logic          ovf_s, udf_s, irq_en_s, push_s;

  logic          access_s, ready_s, commit_s, wr_commit_s, rd_commit_s;
  logic          empty_s, full_s;
  logic [1:0]    reg_sel_s;
  logic [7:0]    count8_s;
  logic [31:0]   status_s, prdata_s;
  logic          unused_s;

  assign reg_sel_s = PADDR[3:2];
  assign unused_s  = ^{PADDR[31:4], PADDR[1:0]};

  assign access_s    = PSEL && PENABLE;
  // Gated by PRESET so a reset during ACCESS drops PREADY immediately
  assign ready_s     = !PRESET && access_s && (wcnt_r == WS_LAST);
  assign commit_s    = ready_s;
  assign wr_commit_s = commit_s && PWRITE;
  assign rd_commit_s = commit_s && !PWRITE;

  assign empty_s  = (count_r == {CW{1'b0}});
  assign full_s   = (count_r == CNT_FULL);
  assign count8_s = 8'(count_r);
  assign status_s = {16'h0000, count8_s, 4'h0, udf_r, ovf_r, full_s, empty_s};

  // Wait-state counter: counts stalled ACCESS cycles, clears outside ACCESS and after completion
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      wcnt_r <= 4'd0;
    end else if (!access_s) begin
      wcnt_r <= 4'd0;
    end else if (!ready_s) begin
      wcnt_r <= wcnt_r + 4'd1;
    end else begin
      wcnt_r <= 4'd0;
    end
  end

  // Next-state decode of the committing transfer (push, pop, flush, W1C, irq_en)
  always_comb begin
    wr_ptr_s = wr_ptr_r;
    rd_ptr_s = rd_ptr_r;
    count_s  = count_r;
    ovf_s    = ovf_r;
    udf_s    = udf_r;
    irq_en_s = irq_en_r;
    push_s   = 1'b0;
    case (reg_sel_s)
      REG_STATUS: begin
        if (wr_commit_s && PWDATA[2]) begin
          ovf_s = 1'b0;
        end else begin
          ovf_s = ovf_r;
        end
        if (wr_commit_s && PWDATA[3]) begin
          udf_s = 1'b0;
        end else begin
          udf_s = udf_r;
        end
      end
      REG_TXDATA: begin
        if (wr_commit_s && full_s) begin
          ovf_s = 1'b1;
        end else if (wr_commit_s) begin
          push_s   = 1'b1;
          wr_ptr_s = wr_ptr_r + {{(AW-1){1'b0}}, 1'b1};
          count_s  = count_r + {{(CW-1){1'b0}}, 1'b1};
        end else begin
          push_s = 1'b0;
        end
      end
      REG_RXDATA: begin
        if (rd_commit_s && empty_s) begin
          udf_s = 1'b1;
        end else if (rd_commit_s) begin
          rd_ptr_s = rd_ptr_r + {{(AW-1){1'b0}}, 1'b1};
          count_s  = count_r - {{(CW-1){1'b0}}, 1'b1};
        end else begin
          rd_ptr_s = rd_ptr_r;
        end
      end
      REG_CTRL: begin
        if (wr_commit_s) begin
          irq_en_s = PWDATA[0];
        end else begin
          irq_en_s = irq_en_r;
        end
        if (wr_commit_s && PWDATA[1]) begin
          wr_ptr_s = {AW{1'b0}};
          rd_ptr_s = {AW{1'b0}};
          count_s  = {CW{1'b0}};
        end else begin
          count_s = count_r;
        end
      end
      default: begin
        push_s = 1'b0;
      end
    endcase
  end

  // FIFO control and status state register
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
      ovf_r    <= 1'b0;
      udf_r    <= 1'b0;
      irq_en_r <= 1'b0;
    end else begin
      wr_ptr_r <= wr_ptr_s;
      rd_ptr_r <= rd_ptr_s;
      count_r  <= count_s;
      ovf_r    <= ovf_s;
      udf_r    <= udf_s;
      irq_en_r <= irq_en_s;
    end
  end

  // FIFO storage write on a committed push
  always_ff @(posedge PCLK) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= PWDATA;
    end
  end

  // Level interrupt registered from current state, so it lags the commit by one cycle
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      irq_r <= 1'b0;
    end else begin
      irq_r <= irq_en_r && !empty_s;
    end
  end

  // Read data mux, only driven during a completing read
  always_comb begin
    prdata_s = 32'h0000_0000;
    if (ready_s && !PWRITE) begin
      case (reg_sel_s)
        REG_STATUS: prdata_s = status_s;
        REG_TXDATA: prdata_s = 32'h0000_0000;
        REG_RXDATA: prdata_s = empty_s ? 32'h0000_0000 : mem_r[rd_ptr_r];
        REG_CTRL:   prdata_s = {31'h0000_0000, irq_en_r};
        default:    prdata_s = 32'h0000_0000;
      endcase
    end else begin
      prdata_s = 32'h0000_0000;
    end
  end

  assign PRDATA = prdata_s;
  assign PREADY = ready_s;
  assign irq    = irq_r;

endmodule
